// File: rtl/spi_cmd_rx.sv
// SPI-slave command receiver: oversampled SPI words feed a per-channel register file and a valid/ready stream.
// Optional SPI_CMD_RX_READBACK_EN adds an sdo port that returns the last committed word during the next frame.
module spi_cmd_rx #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 4,
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CPHA_RISE   = 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               sck,
  input  logic                               sdi,
  input  logic                               ss_n,
  output logic                               rx_valid,
  input  logic                               rx_ready,
  output logic [ADDR_W-1:0]                  rx_addr,
  output logic [DATA_W-ADDR_W-1:0]           rx_data,
  output logic [NUM_CH*(DATA_W-ADDR_W)-1:0]  ch_regs,
  output logic                               frame_err,
  output logic                               bad_addr,
  output logic                               overflow
`ifdef SPI_CMD_RX_READBACK_EN
  ,
  output logic                               sdo
`endif
);

  localparam int PW    = DATA_W - ADDR_W;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [ADDR_W:0] NUM_CH_L = (ADDR_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sdi_sync_q, ss_sync_q;
  logic                   sck_prev_q, ss_prev_q;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic                   rx_valid_q, overflow_q, frame_err_q, bad_addr_q;
  logic [ADDR_W-1:0]      rx_addr_q;
  logic [PW-1:0]          rx_data_q;

  logic                   sck_s, sdi_s, ss_s;
  logic                   sample_edge, ss_fall, commit, frame_err_d, addr_ok;
  logic [DATA_W-1:0]      shifted;
  logic [ADDR_W-1:0]      word_addr;
  logic [PW-1:0]          word_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      ss_sync_q  <= '0;
      sck_prev_q <= 1'b0;
      ss_prev_q  <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      ss_sync_q  <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
      sck_prev_q <= sck_s;
      ss_prev_q  <= ss_s;
    end
  end

  assign sck_s       = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s       = sdi_sync_q[SYNC_STAGES-1];
  assign ss_s        = ss_sync_q[SYNC_STAGES-1];
  assign sample_edge = (CPHA_RISE != 0) ? (sck_s & ~sck_prev_q) : (~sck_s & sck_prev_q);
  // A frame only starts on a seen falling ss_n, so a select held low across reset is ignored.
  assign ss_fall     = ss_prev_q & ~ss_s;
  assign shifted     = {shift_q[DATA_W-2:0], sdi_s};
  assign word_addr   = shift_q[DATA_W-1 -: ADDR_W];
  assign word_data   = shift_q[PW-1:0];
  assign addr_ok     = {1'b0, word_addr} < NUM_CH_L;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    commit      = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (ss_fall) begin
          state_d = SHIFT;
          if (sample_edge) begin
            shift_d   = shifted;
            bit_cnt_d = CNT_W'(1);
          end
        end
      end
      SHIFT: begin
        if (ss_s) begin
          frame_err_d = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
          state_d     = IDLE;
        end else if (sample_edge) begin
          shift_d = shifted;
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            bit_cnt_d = CNT_W'(DATA_W);
            state_d   = COMMIT;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        bit_cnt_d = '0;
        if (ss_s) begin
          state_d = IDLE;
        end else begin
          state_d = SHIFT;
          if (sample_edge) begin
            shift_d   = shifted;
            bit_cnt_d = CNT_W'(1);
          end
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  // A held word wins over a new commit; the newcomer only reaches the register file.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_valid_q  <= 1'b0;
      rx_addr_q   <= '0;
      rx_data_q   <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      bad_addr_q  <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      bad_addr_q  <= commit & ~addr_ok;
      if (commit && (!rx_valid_q || rx_ready)) begin
        rx_valid_q <= 1'b1;
        rx_addr_q  <= word_addr;
        rx_data_q  <= word_data;
      end else begin
        if (commit) overflow_q <= 1'b1;
        if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [PW-1:0] ch_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ch_q <= '0;
      else if (commit && word_addr == ADDR_W'(g)) ch_q <= word_data;
    end
    assign ch_regs[g*PW +: PW] = ch_q;
  end

  assign rx_valid  = rx_valid_q;
  assign rx_addr   = rx_addr_q;
  assign rx_data   = rx_data_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;
  assign bad_addr  = bad_addr_q;

`ifdef SPI_CMD_RX_READBACK_EN
  logic              nonsample_edge;
  logic [DATA_W-1:0] rb_q, rb_sh;
  logic              sdo_q;

  assign nonsample_edge = (CPHA_RISE != 0) ? (~sck_s & sck_prev_q) : (sck_s & ~sck_prev_q);
  // Bit k of the stored word goes out after k bits of the current frame have been sampled.
  assign rb_sh          = rb_q << bit_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rb_q  <= '0;
      sdo_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    sdo_q <= ss_fall ? rb_q[DATA_W-1] : 1'b0;
        COMMIT: begin
          rb_q  <= shift_q;
          sdo_q <= ss_s ? 1'b0 : shift_q[DATA_W-1];
        end
        default: if (nonsample_edge && !ss_s) sdo_q <= rb_sh[DATA_W-1];
      endcase
    end
  end

  assign sdo = sdo_q;
`endif

endmodule

// File: doc/spi_cmd_rx.md
Name: spi_cmd_rx

Overview:
- Parametrised SPI-slave command receiver; successor to the fixed 16-bit SPI input path of the synth1 top level.
- Oversamples sck/sdi/ss_n on the system clock and assembles DATA_W-bit words, MSB first.
- Splits each word into channel address + payload and writes it into a per-channel parameter register file (pitch, gain, etc. for NUM_CH voices).
- Also offers each word on a valid/ready stream for downstream sequencing logic.

Parameters:
- DATA_W, 16: SPI word length in bits, 8..32.
- ADDR_W, 4: number of top word bits that form the channel address.
- NUM_CH, 8: number of channel registers, 1..2^ADDR_W.
- SYNC_STAGES, 2: synchroniser depth on sck, sdi and ss_n, >=2.
- CPHA_RISE, 1: 1 = sample sdi on rising sck; 0 = sample on falling sck.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- sck  in  1  SPI clock, asynchronous to clk; frequency <= clk/4.
- sdi  in  1  SPI data in.
- ss_n  in  1  slave select, active-low.
- rx_valid  out  1  word available on the stream.
- rx_ready  in  1  downstream accepts the word.
- rx_addr  out  ADDR_W  channel address of the presented word.
- rx_data  out  DATA_W-ADDR_W  payload of the presented word.
- ch_regs  out  NUM_CH*(DATA_W-ADDR_W)  flattened register file; channel n occupies slice n.
- frame_err  out  1  one-cycle pulse on a truncated frame.
- bad_addr  out  1  one-cycle pulse when the address is >= NUM_CH.
- overflow  out  1  sticky flag for a word dropped on the stream; cleared only by reset.

Behaviour:
- Reset: every output and internal register is 0, bit counter is 0, synchronisers are cleared.
- sck, sdi and ss_n each pass through SYNC_STAGES flip-flops. The sample edge is detected from the last two synchronised sck values. sdi uses the same number of stages so it stays aligned with sck.
- Shift: on a sample edge with synchronised ss_n=0, shift sdi into the LSB and increment bit_cnt. Data is received MSB first.
- States: IDLE (ss_n=1), SHIFT (ss_n=0, bit_cnt<DATA_W), COMMIT (1 cycle).
  - IDLE -> SHIFT when ss_n falls.
  - SHIFT -> COMMIT when bit_cnt reaches DATA_W.
  - COMMIT -> SHIFT if ss_n is still 0 (back-to-back words, bit_cnt wraps to 0); otherwise -> IDLE.
  - ss_n held low forever is legal and gives a continuous stream of words.
- COMMIT: addr = word[DATA_W-1 -: ADDR_W], payload = the low bits.
  - If addr < NUM_CH: ch_regs slice addr <= payload, visible 1 clk after COMMIT.
  - If addr >= NUM_CH: bad_addr pulses, register file is unchanged, word is still offered on the stream.
- Stream:
  - rx_valid rises the clk after COMMIT.
  - rx_addr/rx_data are held stable while rx_valid=1 && rx_ready=0.
  - Transfer happens on rx_valid && rx_ready. rx_valid then drops the next clk unless a new COMMIT occurs in the same cycle.
  - If a new word commits while rx_valid=1 and rx_ready=0: the new word is dropped from the stream (register file still updated), overflow is set, and the old word stays presented.
  - Commit in the same cycle as an accepted transfer: the new word replaces the old one, rx_valid stays 1, no overflow.
- Synchronised ss_n rising with 0 < bit_cnt < DATA_W: frame_err pulses, the partial word is discarded, bit_cnt resets to 0, nothing is committed.
- ss_n rising with bit_cnt=0: no error.
- Sample edges while ss_n=1 are ignored.
- Latency: last sample edge at the pin -> rx_valid = SYNC_STAGES+2 clk.
- Reset asserted mid-frame: everything clears immediately. The first frame after reset_n deasserts is received only if ss_n falls after the release.

Optional Feature:
- Macro: SPI_CMD_RX_READBACK_EN.
- Defined: adds port sdo (out, 1). The last committed word is shifted out MSB first during the next frame, updated on the non-sample sck edge. sdo=0 in IDLE and after reset.
- Undefined: no sdo port and no readback shift register; all other behaviour is identical.

Test Plan:
- Defaults, ss_n held 0, continuous word 16'h01AB, sck=clk/10 -> rx_addr=0, rx_data=12'h1AB, ch_regs[11:0]=12'h1AB, one commit every 16 sck periods, no errors.
- Send 16'h3FFF then 16'h7123 with rx_ready=1 -> ch3=12'hFFF, ch7=12'h123, two stream transfers, overflow=0.
- Send 16'h9ABC (addr 9 >= NUM_CH=8) -> bad_addr pulses once, ch_regs unchanged, stream word addr 9 / data 12'hABC.
- Raise ss_n after 9 bits of 16'h2555 -> frame_err pulses once, no commit; a following complete 16'h2555 gives ch2=12'h555.
- rx_ready=0, send 16'h1111 then 16'h1222 -> stream holds addr 1 / data 12'h111, overflow=1, ch1=12'h222.
- With READBACK_EN: send 16'h01AB then 16'h0000 -> sdo shifts 0000_0001_1010_1011 during the second frame; assert reset_n=0 mid-frame -> all outputs 0 immediately.
